data_bus_responder: RTL and testbench

Data-side bus responder for the pipelined MIPS core. It answers load/store requests from the MEM stage with a valid/ready request and a one-cycle response pulse. It contains a word-addressed data RAM, a memory-mapped output port register driving PortOut, and a synchronized memory-mapped input port sampling PortIn. A configurable number of wait states lets the pipeline's MEM-stage stall logic be exercised.

---
 rtl/data_bus_responder_if.sv | 25 ++
 rtl/data_bus_responder.sv | 155 +++++++++++++++
 tb/tb_data_bus_responder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/data_bus_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-side
// responder (slave).
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// the responder answers with a single-cycle rsp_valid pulse carrying
// rsp_rdata/rsp_error, and the master must accept it unconditionally.
interface data_bus_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_bus_responder.sv
// Data-side bus responder: word RAM, PortOut register and synchronized PortIn,
// with a programmable number of wait states between acceptance and access.
module data_bus_responder #(
    parameter int          MEMORY_DEPTH = 64,
    parameter int          WAIT_STATES  = 1,
    parameter logic [31:0] RAM_BASE     = 32'h1001_0000,
    parameter logic [31:0] IO_OUT_ADDR  = 32'h1001_0400,
    parameter logic [31:0] IO_IN_ADDR   = 32'h1001_0404
) (
    input  logic                 clk,
    input  logic                 reset,
    data_bus_responder_if.slave  bus,
    input  logic [7:0]           PortIn,
    output logic [31:0]          PortOut,
    output logic [1:0]           dbg_state
);

    localparam int          IDX_W   = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
    localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(4 * MEMORY_DEPTH);
    localparam logic [3:0]  WS      = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        rsp_valid_q;
    logic        rsp_error_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] port_out_q;
    logic [7:0]  sync1;
    logic [7:0]  sync2;
    logic [31:0] mem [MEMORY_DEPTH];

    logic             accept;
    logic             do_access;
    logic             acc_write;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [IDX_W-1:0] ram_idx;
    logic             in_ram;
    logic [31:0]      acc_rdata;
    logic             acc_error;
    logic             ram_we;
    logic             port_we;

    assign bus.req_ready = (state != S_WAIT);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
    assign PortOut       = port_out_q;
    assign dbg_state     = state;

    assign accept = bus.req_valid && bus.req_ready;

    // With zero wait states the access happens on the acceptance edge itself,
    // so the live request is used; otherwise the latched one from WAIT.
    assign do_access = ((state == S_WAIT) && (cnt == 4'd1)) || (accept && (WS == 4'd0));
    assign acc_write = (state == S_WAIT) ? lat_write : bus.req_write;
    assign acc_addr  = (state == S_WAIT) ? lat_addr  : bus.req_addr;
    assign acc_wdata = (state == S_WAIT) ? lat_wdata : bus.req_wdata;

    // RAM_BASE is word aligned, so subtracting the word-index bits gives the
    // same result as (addr - RAM_BASE) >> 2 within the RAM window.
    assign ram_idx = acc_addr[IDX_W+1:2] - RAM_BASE[IDX_W+1:2];
    assign in_ram  = ({1'b0, acc_addr} >= {1'b0, RAM_BASE}) && ({1'b0, acc_addr} < RAM_END);

    // Address decode and read mux for the access in progress.
    always_comb begin
        acc_rdata = 32'd0;
        acc_error = 1'b0;
        ram_we    = 1'b0;
        port_we   = 1'b0;
        if (acc_addr[1:0] != 2'b00) begin
            acc_error = 1'b1;
        end else if (in_ram) begin
            if (acc_write) ram_we    = 1'b1;
            else           acc_rdata = mem[ram_idx];
        end else if (acc_addr == IO_OUT_ADDR) begin
            if (acc_write) port_we   = 1'b1;
            else           acc_rdata = port_out_q;
        end else if (acc_addr == IO_IN_ADDR) begin
            if (acc_write) acc_error = 1'b1;
            else           acc_rdata = {24'd0, sync2};
        end else begin
            acc_error = 1'b1;
        end
    end

    // Two-flop synchronizer for the asynchronous input pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 8'd0;
            sync2 <= 8'd0;
        end else begin
            sync1 <= PortIn;
            sync2 <= sync1;
        end
    end

    // RAM write port; contents survive reset, and a reset edge blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && do_access && ram_we) begin
            mem[ram_idx] <= acc_wdata;
        end
    end

    // Request FSM with registered response and PortOut.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            lat_write   <= 1'b0;
            lat_addr    <= 32'd0;
            lat_wdata   <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_error_q <= 1'b0;
            port_out_q  <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                S_IDLE, S_RESP: begin
                    if (bus.req_valid) begin
                        lat_write <= bus.req_write;
                        lat_addr  <= bus.req_addr;
                        lat_wdata <= bus.req_wdata;
                        cnt       <= WS;
                        state     <= (WS == 4'd0) ? S_RESP : S_WAIT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
            if (do_access) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= acc_rdata;
                rsp_error_q <= acc_error;
                if (port_we) port_out_q <= acc_wdata;
            end
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: one instance with one wait state,
// one with zero wait states, sharing clock and reset.
module tb_data_bus_responder;

    localparam logic [31:0] RAM_BASE = 32'h1001_0000;
    localparam logic [31:0] IO_OUT   = 32'h1001_0400;
    localparam logic [31:0] IO_IN    = 32'h1001_0404;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  port_in = 8'd0;
    logic [7:0]  port_in0 = 8'd0;
    logic [31:0] port_out;
    logic [31:0] port_out0;
    logic [1:0]  state;
    logic [1:0]  state0;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    data_bus_responder_if m_if ();
    data_bus_responder_if z_if ();

    data_bus_responder #(.WAIT_STATES(1)) dut (
        .clk(clk), .reset(reset), .bus(m_if),
        .PortIn(port_in), .PortOut(port_out), .dbg_state(state)
    );

    data_bus_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(z_if),
        .PortIn(port_in0), .PortOut(port_out0), .dbg_state(state0)
    );

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
        end
    endtask

    // One isolated transaction on the one-wait-state instance; call at a negedge
    // with the FSM idle. Returns at a negedge with the FSM idle again.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int n;
        chk({tag, "_ready_idle"}, {31'd0, m_if.req_ready}, 32'd1);
        m_if.req_valid = 1'b1;
        m_if.req_write = w;
        m_if.req_addr  = a;
        m_if.req_wdata = d;
        @(negedge clk);
        m_if.req_valid = 1'b0;
        m_if.req_write = 1'b0;
        m_if.req_addr  = 32'd0;
        m_if.req_wdata = 32'd0;
        chk({tag, "_ready_wait"}, {31'd0, m_if.req_ready}, 32'd0);
        n = 1;
        while (m_if.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd2);
        chk({tag, "_rdata"}, m_if.rsp_rdata, exp_rd);
        chk({tag, "_error"}, {31'd0, m_if.rsp_error}, {31'd0, exp_err});
        @(negedge clk);
        chk({tag, "_pulse_end"}, {31'd0, m_if.rsp_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] e;
        m_if.req_valid = 1'b0; m_if.req_write = 1'b0;
        m_if.req_addr  = 32'd0; m_if.req_wdata = 32'd0;
        z_if.req_valid = 1'b0; z_if.req_write = 1'b0;
        z_if.req_addr  = 32'd0; z_if.req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // reset state
        chk("rst_rsp_valid", {31'd0, m_if.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", m_if.rsp_rdata, 32'd0);
        chk("rst_rsp_error", {31'd0, m_if.rsp_error}, 32'd0);
        chk("rst_portout", port_out, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_ready", {31'd0, m_if.req_ready}, 32'd1);
        chk("rst0_rsp_valid", {31'd0, z_if.rsp_valid}, 32'd0);
        chk("rst0_portout", port_out0, 32'd0);

        // store then load
        xact(1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'd0, 1'b0, "st_deadbeef");
        xact(1'b0, 32'h1001_0008, 32'd0, 32'hDEAD_BEEF, 1'b0, "ld_deadbeef");

        // pre-write words 0..2 and a known value at 0x10
        xact(1'b1, 32'h1001_0000, 32'd1, 32'd0, 1'b0, "st_w0");
        xact(1'b1, 32'h1001_0004, 32'd2, 32'd0, 1'b0, "st_w1");
        xact(1'b1, 32'h1001_0008, 32'd3, 32'd0, 1'b0, "st_w2");
        xact(1'b1, 32'h1001_0010, 32'h0000_0055, 32'd0, 1'b0, "st_w4");

        // back-to-back loads with req_valid held high
        chk("b2b_ready_start", {31'd0, m_if.req_ready}, 32'd1);
        m_if.req_valid = 1'b1;
        m_if.req_write = 1'b0;
        m_if.req_addr  = RAM_BASE;
        exp_q.push_back(32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_wait_ready", {31'd0, m_if.req_ready}, 32'd0);
            chk("b2b_wait_rsp", {31'd0, m_if.rsp_valid}, 32'd0);
            @(negedge clk);
            chk("b2b_rsp_valid", {31'd0, m_if.rsp_valid}, 32'd1);
            e = exp_q.pop_front();
            chk("b2b_rdata", m_if.rsp_rdata, e);
            chk("b2b_resp_ready", {31'd0, m_if.req_ready}, 32'd1);
            if (i < 2) begin
                m_if.req_addr = RAM_BASE + 32'(4 * (i + 1));
                exp_q.push_back(32'(i + 2));
            end else begin
                m_if.req_valid = 1'b0;
                m_if.req_addr  = 32'd0;
            end
        end
        @(negedge clk);
        chk("b2b_end_rsp", {31'd0, m_if.rsp_valid}, 32'd0);
        chk("b2b_end_state", {30'd0, state}, 32'd0);
        chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // MMIO output and input ports
        xact(1'b1, IO_OUT, 32'h0000_00A5, 32'd0, 1'b0, "st_portout");
        chk("portout_a5", port_out, 32'h0000_00A5);
        xact(1'b0, IO_OUT, 32'd0, 32'h0000_00A5, 1'b0, "ld_portout");
        port_in = 8'h3C;
        repeat (2) @(negedge clk);
        xact(1'b0, IO_IN, 32'd0, 32'h0000_003C, 1'b0, "ld_portin");

        // error cases: no side effects
        xact(1'b0, 32'h1001_0002, 32'd0, 32'd0, 1'b1, "err_misaligned");
        xact(1'b1, IO_IN, 32'h0000_00FF, 32'd0, 1'b1, "err_st_portin");
        xact(1'b0, 32'h0000_0000, 32'd0, 32'd0, 1'b1, "err_unmapped");
        xact(1'b0, 32'h1001_0100, 32'd0, 32'd0, 1'b1, "err_past_ram");
        xact(1'b1, 32'h1001_0006, 32'h1111_1111, 32'd0, 1'b1, "err_st_misaligned");
        chk("err_portout_kept", port_out, 32'h0000_00A5);
        xact(1'b0, 32'h1001_0004, 32'd0, 32'd2, 1'b0, "err_ram_kept1");
        xact(1'b0, 32'h1001_0008, 32'd0, 32'd3, 1'b0, "err_ram_kept2");

        // zero-wait-state instance: store and load in consecutive cycles
        chk("ws0_ready0", {31'd0, z_if.req_ready}, 32'd1);
        z_if.req_valid = 1'b1;
        z_if.req_write = 1'b1;
        z_if.req_addr  = 32'h1001_0020;
        z_if.req_wdata = 32'hCAFE_0001;
        @(negedge clk);
        chk("ws0_st_rsp_valid", {31'd0, z_if.rsp_valid}, 32'd1);
        chk("ws0_st_rdata", z_if.rsp_rdata, 32'd0);
        chk("ws0_st_error", {31'd0, z_if.rsp_error}, 32'd0);
        chk("ws0_ready1", {31'd0, z_if.req_ready}, 32'd1);
        z_if.req_write = 1'b0;
        z_if.req_wdata = 32'd0;
        @(negedge clk);
        chk("ws0_ld_rsp_valid", {31'd0, z_if.rsp_valid}, 32'd1);
        chk("ws0_ld_rdata", z_if.rsp_rdata, 32'hCAFE_0001);
        chk("ws0_ld_error", {31'd0, z_if.rsp_error}, 32'd0);
        chk("ws0_ready2", {31'd0, z_if.req_ready}, 32'd1);
        z_if.req_valid = 1'b0;
        z_if.req_addr  = 32'd0;
        @(negedge clk);
        chk("ws0_idle_rsp", {31'd0, z_if.rsp_valid}, 32'd0);

        // reset during the WAIT cycle of a store drops it
        chk("rstmid_ready", {31'd0, m_if.req_ready}, 32'd1);
        m_if.req_valid = 1'b1;
        m_if.req_write = 1'b1;
        m_if.req_addr  = 32'h1001_0010;
        m_if.req_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("rstmid_in_wait", {30'd0, state}, 32'd1);
        m_if.req_valid = 1'b0;
        m_if.req_write = 1'b0;
        m_if.req_addr  = 32'd0;
        m_if.req_wdata = 32'd0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_rsp_valid", {31'd0, m_if.rsp_valid}, 32'd0);
        chk("rstmid_portout", port_out, 32'd0);
        chk("rstmid_state", {30'd0, state}, 32'd0);
        @(negedge clk);
        chk("rstmid_rsp_valid2", {31'd0, m_if.rsp_valid}, 32'd0);
        xact(1'b0, 32'h1001_0010, 32'd0, 32'h0000_0055, 1'b0, "rstmid_ram_kept");

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
